// File: rtl/pa_frame_energy_vad_if.sv
// pa_frame_energy_vad_if: sample, control, threshold and result bundle for the frame-energy VAD.
// Ports (as seen by the slave/DUT):
//   in:  data_in, en, clear, thr_on, thr_off
//   out: energy_out, energy_valid, energy_sat, vad_active, vad_start, vad_end
interface pa_frame_energy_vad_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 26
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  en;
    logic                  clear;
    logic [ACC_WIDTH-1:0]  thr_on;
    logic [ACC_WIDTH-1:0]  thr_off;
    logic [ACC_WIDTH-1:0]  energy_out;
    logic                  energy_valid;
    logic                  energy_sat;
    logic                  vad_active;
    logic                  vad_start;
    logic                  vad_end;
    modport master (
        output data_in, en, clear, thr_on, thr_off,
        input  energy_out, energy_valid, energy_sat, vad_active, vad_start, vad_end
    );
    modport slave (
        input  data_in, en, clear, thr_on, thr_off,
        output energy_out, energy_valid, energy_sat, vad_active, vad_start, vad_end
    );
endinterface

// File: rtl/pa_frame_energy_vad.sv
// pa_frame_energy_vad: per-frame short-time energy with saturation and a hysteresis/hangover VAD.
// Ports: clk, rst (sync, active-high); bus (slave) carries samples/en/clear/thresholds in and
// energy_out/energy_valid/energy_sat/vad_active/vad_start/vad_end out.
module pa_frame_energy_vad #(
    parameter int DATA_WIDTH   = 16,
    parameter int SHIFT        = 8,
    parameter int FRAME_LOG2   = 10,
    parameter int ACC_WIDTH    = 26,
    parameter int ONSET_FRAMES = 3,
    parameter int HANG_FRAMES  = 8
) (
    input logic clk,
    input logic rst,
    pa_frame_energy_vad_if.slave bus
);
    localparam int M  = DATA_WIDTH - SHIFT;
    localparam int CW = $clog2((ONSET_FRAMES > HANG_FRAMES ? ONSET_FRAMES : HANG_FRAMES) + 1);
    typedef enum logic [1:0] {SIL, ONSET, SPEECH, HANG} state_t;
    logic [M-1:0]            s;
    logic [M-1:0]            mag;
    logic [2*M-1:0]          sq;
    logic                    sq_valid;
    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic [ACC_WIDTH:0]      sum;
    logic                    sat;
    logic                    sat_next;
    logic [FRAME_LOG2-1:0]   count;
    logic                    last;
    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic                    start_n, end_n;
    // The upper M bits of the sample are exactly the arithmetic-shift result.
    assign s        = bus.data_in[DATA_WIDTH-1:SHIFT];
    assign mag      = s[M-1] ? M'(0) - s : s;
    assign sum      = {1'b0, acc} + (ACC_WIDTH+1)'(sq);
    assign sat_next = sat | sum[ACC_WIDTH];
    assign acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    assign last     = sq_valid && &count;
    assign bus.vad_active = (state == SPEECH) || (state == HANG);
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_valid         <= 1'b0;
            sq               <= '0;
            acc              <= '0;
            sat              <= 1'b0;
            count            <= '0;
            bus.energy_out   <= '0;
            bus.energy_valid <= 1'b0;
            bus.energy_sat   <= 1'b0;
        end else if (bus.clear) begin
            sq_valid         <= 1'b0;
            acc              <= '0;
            sat              <= 1'b0;
            count            <= '0;
            bus.energy_valid <= 1'b0;
        end else begin
            sq_valid         <= bus.en;
            bus.energy_valid <= last;
            if (bus.en)
                sq <= (2*M)'(mag) * (2*M)'(mag);
            // Closing sample reloads the frame state so the next sample starts a fresh frame.
            if (sq_valid) begin
                count <= count + FRAME_LOG2'(1);
                acc   <= last ? '0 : acc_next;
                sat   <= !last && sat_next;
            end
            if (last) begin
                bus.energy_out <= acc_next;
                bus.energy_sat <= sat_next;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SIL;
            cnt           <= '0;
            bus.vad_start <= 1'b0;
            bus.vad_end   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.vad_start <= start_n;
            bus.vad_end   <= end_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start_n = 1'b0;
        end_n   = 1'b0;
        if (bus.energy_valid) begin
            case (state)
                SIL: if (bus.energy_out >= bus.thr_on) begin
                    state_n = ONSET_FRAMES == 1 ? SPEECH : ONSET;
                    start_n = ONSET_FRAMES == 1;
                    cnt_n   = CW'(1);
                end
                ONSET: if (bus.energy_out < bus.thr_on) begin
                    state_n = SIL;
                end else if (cnt == CW'(ONSET_FRAMES - 1)) begin
                    state_n = SPEECH;
                    start_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                SPEECH: if (bus.energy_out < bus.thr_off) begin
                    state_n = HANG_FRAMES == 1 ? SIL : HANG;
                    end_n   = HANG_FRAMES == 1;
                    cnt_n   = CW'(1);
                end
                HANG: if (bus.energy_out >= bus.thr_off) begin
                    state_n = SPEECH;
                end else if (cnt == CW'(HANG_FRAMES - 1)) begin
                    state_n = SIL;
                    end_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                default: state_n = SIL;
            endcase
        end
    end
endmodule

// File: tb/tb_pa_frame_energy_vad.sv
// tb_pa_frame_energy_vad: directed self-checking bench for pa_frame_energy_vad (default and ACC_WIDTH=20 instances).
module tb_pa_frame_energy_vad;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int starts = 0;
    int ends = 0;
    int ends_before;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic s0[$];
    logic s1[$];

    always #5 clk = ~clk;

    pa_frame_energy_vad_if #(.DATA_WIDTH(16), .ACC_WIDTH(26)) b0 ();
    pa_frame_energy_vad_if #(.DATA_WIDTH(16), .ACC_WIDTH(20)) b1 ();

    pa_frame_energy_vad #(.ONSET_FRAMES(3), .HANG_FRAMES(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pa_frame_energy_vad #(.ACC_WIDTH(20)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    always @(posedge clk) begin
        if (b0.energy_valid) begin q0.push_back(32'(b0.energy_out)); s0.push_back(b0.energy_sat); end
        if (b1.energy_valid) begin q1.push_back(32'(b1.energy_out)); s1.push_back(b1.energy_sat); end
        if (b0.vad_start) starts++;
        if (b0.vad_end) ends++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic e, input logic c);
        b0.data_in = d; b1.data_in = d;
        b0.en = e;      b1.en = e;
        b0.clear = c;   b1.clear = c;
    endtask

    task automatic send(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, 1'b0);
            tick();
        end
        drive(d, 1'b0, 1'b0);
    endtask

    task automatic gapped(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, 1'b0);
            tick();
            drive(d, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic idle(input int n);
        drive(16'h0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flush();
        q0.delete(); q1.delete(); s0.delete(); s1.delete();
    endtask

    // Frame whose energy is n (n samples of magnitude 1, rest zero).
    task automatic frame(input int n);
        send(16'h0100, n);
        send(16'h0000, 1024 - n);
        idle(3);
    endtask

    task automatic expect0(input string tag, input logic [31:0] e, input logic s);
        chk({tag, "_n0"}, q0.size(), 1);
        if (q0.size() > 0) begin
            chk({tag, "_e0"}, q0[0], e);
            chk({tag, "_s0"}, 32'(s0[0]), 32'(s));
        end
        q0.delete(); s0.delete();
    endtask

    task automatic expect1(input string tag, input logic [31:0] e, input logic s);
        chk({tag, "_n1"}, q1.size(), 1);
        if (q1.size() > 0) begin
            chk({tag, "_e1"}, q1[0], e);
            chk({tag, "_s1"}, 32'(s1[0]), 32'(s));
        end
        q1.delete(); s1.delete();
    endtask

    initial begin
        drive(16'h0, 1'b0, 1'b0);
        b0.thr_on = '1; b0.thr_off = '0;
        b1.thr_on = '1; b1.thr_off = '0;
        rst = 1'b1;
        idle(3);
        chk("rst_eo", 32'(b0.energy_out), 0);
        chk("rst_ev", 32'(b0.energy_valid), 0);
        chk("rst_sat", 32'(b0.energy_sat), 0);
        chk("rst_act", 32'(b0.vad_active), 0);
        chk("rst_st", 32'(b0.vad_start), 0);
        chk("rst_end", 32'(b0.vad_end), 0);
        rst = 1'b0;
        idle(2);
        flush();

        send(16'h0100, 1024);
        chk("t1_ev_early", 32'(b0.energy_valid), 0);
        tick();
        chk("t1_ev", 32'(b0.energy_valid), 1);
        chk("t1_eo", 32'(b0.energy_out), 1024);
        chk("t1_sat", 32'(b0.energy_sat), 0);
        tick();
        chk("t1_ev_low", 32'(b0.energy_valid), 0);
        idle(2);
        expect0("t1", 1024, 1'b0);
        expect1("t1", 1024, 1'b0);

        send(16'h8000, 1024);
        send(16'h7FFF, 1024);
        idle(3);
        chk("t2_n0", q0.size(), 2);
        chk("t2_n1", q1.size(), 2);
        if (q0.size() == 2) begin
            chk("t2_e0a", q0[0], 32'h100_0000);
            chk("t2_s0a", 32'(s0[0]), 0);
            chk("t2_e0b", q0[1], 32'd16516096);
            chk("t2_s0b", 32'(s0[1]), 0);
        end
        if (q1.size() == 2) begin
            chk("t2_e1a", q1[0], 32'hFFFFF);
            chk("t2_s1a", 32'(s1[0]), 1);
            chk("t2_e1b", q1[1], 32'hFFFFF);
            chk("t2_s1b", 32'(s1[1]), 1);
        end
        flush();

        gapped(16'h0100, 500);
        idle(50);
        gapped(16'h0100, 523);
        idle(3);
        chk("t3_early", q0.size(), 0);
        gapped(16'h0100, 1);
        idle(3);
        expect0("t3", 1024, 1'b0);
        expect1("t3", 1024, 1'b0);

        b0.thr_on = 26'd1000; b0.thr_off = 26'd500;
        frame(1024); frame(1024); frame(0); frame(1024); frame(1024);
        chk("v_pre_starts", starts, 0);
        chk("v_pre_act", 32'(b0.vad_active), 0);
        send(16'h0100, 1024);
        tick();
        chk("v6_ev", 32'(b0.energy_valid), 1);
        chk("v6_act_before", 32'(b0.vad_active), 0);
        tick();
        chk("v6_act", 32'(b0.vad_active), 1);
        chk("v6_start", 32'(b0.vad_start), 1);
        tick();
        chk("v6_start_low", 32'(b0.vad_start), 0);
        idle(2);
        chk("v6_starts", starts, 1);
        frame(600); frame(0); frame(0); frame(0); frame(1024);
        chk("vh_act", 32'(b0.vad_active), 1);
        chk("vh_ends", ends, 0);
        frame(0); frame(0); frame(0);
        chk("ve_act_pre", 32'(b0.vad_active), 1);
        send(16'h0000, 1024);
        tick();
        tick();
        chk("ve_end", 32'(b0.vad_end), 1);
        chk("ve_act", 32'(b0.vad_active), 0);
        tick();
        chk("ve_end_low", 32'(b0.vad_end), 0);
        chk("ve_ends", ends, 1);
        chk("ve_starts", starts, 1);
        idle(2);
        flush();

        b0.thr_on = '1;
        send(16'h0100, 700);
        drive(16'h7FFF, 1'b1, 1'b1);
        tick();
        idle(1);
        send(16'h0100, 1023);
        idle(3);
        chk("clr_early", q0.size(), 0);
        send(16'h0100, 1);
        idle(3);
        expect0("clr", 1024, 1'b0);
        expect1("clr", 1024, 1'b0);

        b0.thr_on = 26'd1000;
        frame(1024); frame(1024); frame(1024);
        chk("r_act_pre", 32'(b0.vad_active), 1);
        flush();
        ends_before = ends;
        send(16'h0100, 300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_eo", 32'(b0.energy_out), 0);
        chk("r_ev", 32'(b0.energy_valid), 0);
        chk("r_sat", 32'(b0.energy_sat), 0);
        chk("r_act", 32'(b0.vad_active), 0);
        chk("r_st", 32'(b0.vad_start), 0);
        chk("r_end", 32'(b0.vad_end), 0);
        send(16'h0100, 1023);
        idle(3);
        chk("r_early", q0.size(), 0);
        send(16'h0100, 1);
        idle(3);
        expect0("r", 1024, 1'b0);
        chk("r_ends", ends, ends_before);
        chk("r_act_post", 32'(b0.vad_active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
